// File: rtl/note_sequencer.sv
// Tempo-driven record/playback note sequencer for a string x bar contact grid.
// Notes are captured once per beat into an inferred memory and replayed on the same beat grid.
module note_sequencer #(
  parameter int unsigned NUM_STRINGS = 6,
  parameter int unsigned NUM_BARS    = 4,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned PERIOD_W    = 27,
  parameter int unsigned GUARD       = 10000
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   cmd_record,
  input  logic                                   cmd_play,
  input  logic                                   cmd_stop,
  input  logic                                   loop_en,
  input  logic [PERIOD_W-1:0]                    beat_period,
  input  logic [NUM_STRINGS-1:0]                 strings,
  input  logic [NUM_BARS-1:0]                    bars,
  output logic                                   beat,
  output logic [NUM_STRINGS*(NUM_BARS+1)-1:0]    note_out,
  output logic                                   note_valid,
  output logic [ADDR_W-1:0]                      address,
  output logic [ADDR_W:0]                        length,
  output logic                                   full,
  output logic [1:0]                             state
);

  localparam int unsigned NOTE_W = NUM_STRINGS*(NUM_BARS+1);
  localparam int unsigned FRET_W = NUM_BARS+1;
  localparam int unsigned LEN_W  = ADDR_W+1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REC = 2'd1, S_PLAY = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [PERIOD_W-1:0]    cnt_q, cnt_d;
  logic [PERIOD_W-1:0]    p_q, p_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [NUM_STRINGS-1:0] s_acc_q, s_acc_d;
  logic [FRET_W-1:0]      f_acc_q, f_acc_d;
  logic [NOTE_W-1:0]      note_q, note_d;
  logic                   valid_q, valid_d;
  logic                   we_c;
  logic [NOTE_W-1:0]      mem [DEPTH];

  logic [PERIOD_W-1:0]    p_c;
  logic                   beat_c, capture_c, rec_full_c, play_last_c;
  logic [FRET_W-1:0]      fret_c;
  logic [NOTE_W-1:0]      note_c;

  assign p_c         = (beat_period < PERIOD_W'(2)) ? PERIOD_W'(2) : beat_period;
  assign beat_c      = (state_q != S_IDLE) && (cnt_q == '0);
  // p_q holds the period of the beat in progress so the window tracks the running beat
  assign capture_c   = (state_q == S_REC) && (cnt_q != '0) && (32'(p_q) > GUARD) &&
                       (32'(cnt_q) < (32'(p_q) - GUARD));
  assign rec_full_c  = (len_q + LEN_W'(1)) == LEN_W'(DEPTH);
  assign play_last_c = (LEN_W'(addr_q) + LEN_W'(1)) == len_q;

  // Highest pressed bar wins; no bar pressed means open string
  always_comb begin
    fret_c = FRET_W'(1);
    for (int i = 0; i < int'(NUM_BARS); i++) begin
      if (bars[i]) fret_c = FRET_W'(1) << (i + 1);
    end
  end

  always_comb begin
    note_c = '0;
    for (int k = 0; k < int'(FRET_W); k++) begin
      for (int s = 0; s < int'(NUM_STRINGS); s++) begin
        note_c[k*NUM_STRINGS + s] = s_acc_q[s] & f_acc_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= PERIOD_W'(2);
      addr_q  <= '0;
      len_q   <= '0;
      s_acc_q <= '0;
      f_acc_q <= '0;
      note_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      s_acc_q <= s_acc_d;
      f_acc_q <= f_acc_d;
      note_q  <= note_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we_c) mem[addr_q] <= note_c;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!cmd_stop) begin
          if (cmd_record)    state_d = S_REC;
          else if (cmd_play) state_d = S_PLAY;
        end
      end
      S_REC: begin
        if (cmd_stop)                  state_d = S_IDLE;
        else if (beat_c && rec_full_c) state_d = S_IDLE;
      end
      S_PLAY: begin
        if (cmd_stop)                                   state_d = S_IDLE;
        else if (len_q == '0)                           state_d = S_IDLE;
        else if (beat_c && play_last_c && !loop_en)     state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    p_d     = p_q;
    addr_d  = addr_q;
    len_d   = len_q;
    s_acc_d = s_acc_q;
    f_acc_d = f_acc_q;
    note_d  = note_q;
    valid_d = 1'b0;
    we_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        note_d  = '0;
        s_acc_d = '0;
        f_acc_d = '0;
        cnt_d   = '0;
        if (!cmd_stop && (cmd_record || cmd_play)) begin
          cnt_d  = p_c - PERIOD_W'(1);
          p_d    = p_c;
          addr_d = '0;
          if (cmd_record) len_d = '0;
        end
      end
      S_REC: begin
        if (cmd_stop) begin
          note_d  = '0;
          s_acc_d = '0;
          f_acc_d = '0;
        end else begin
          if (cnt_q == '0) begin
            cnt_d = p_c - PERIOD_W'(1);
            p_d   = p_c;
          end else begin
            cnt_d = cnt_q - PERIOD_W'(1);
          end
          if (beat_c) begin
            we_c    = 1'b1;
            note_d  = note_c;
            valid_d = 1'b1;
            s_acc_d = '0;
            f_acc_d = '0;
            len_d   = len_q + LEN_W'(1);
            // The last slot keeps its address so REC never wraps
            if (!rec_full_c) addr_d = addr_q + ADDR_W'(1);
          end else if (capture_c) begin
            s_acc_d = s_acc_q | strings;
            f_acc_d = f_acc_q | fret_c;
          end
        end
      end
      S_PLAY: begin
        if (cmd_stop) begin
          note_d = '0;
        end else begin
          if (cnt_q == '0) begin
            cnt_d = p_c - PERIOD_W'(1);
            p_d   = p_c;
          end else begin
            cnt_d = cnt_q - PERIOD_W'(1);
          end
          if (beat_c && (len_q != '0)) begin
            note_d  = mem[addr_q];
            valid_d = 1'b1;
            addr_d  = play_last_c ? '0 : addr_q + ADDR_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign beat       = beat_c;
  assign note_out   = note_q;
  assign note_valid = valid_q;
  assign address    = addr_q;
  assign length     = len_q;
  assign full       = len_q == LEN_W'(DEPTH);
  assign state      = state_q;

endmodule
